act_unit_pipe: RTL

Multi-lane, mode-selectable activation stage for the CNN datapath. It replaces the single-lane combinational ReLU with a 2-stage pipelined unit that applies bypass, ReLU, clamped ReLU (ReLU6-style) or leaky ReLU to LANES signed elements per beat. It uses a valid/ready handshake and keeps a sparsity counter of zeroed outputs. It sits between the accumulator/requantiser output and the pooling / output-buffer write path.

---
 rtl/act_unit_pipe.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/act_unit_pipe.sv
// Two-stage pipelined multi-lane activation (bypass / ReLU / clamped ReLU / leaky ReLU)
// with valid/ready flow control and a saturating count of zero-valued output lanes.
module act_unit_pipe #(
  parameter int WIDTH      = 8,
  parameter int LANES      = 4,
  parameter int LEAK_SHIFT = 3,
  parameter int CNT_W      = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             mode,
  input  logic [WIDTH-1:0]       clamp_val,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic                   out_last,
  output logic [CNT_W-1:0]       zero_cnt,
  input  logic                   stat_clr
);

  localparam logic [1:0] MODE_BYPASS = 2'b00;
  localparam logic [1:0] MODE_RELU   = 2'b01;
  localparam logic [1:0] MODE_CLAMP  = 2'b10;
  localparam logic [1:0] MODE_LEAKY  = 2'b11;

  logic                    s1_valid_reg;
  logic                    s2_valid_reg;
  logic                    s1_last_reg;
  logic                    s2_last_reg;
  logic [1:0]              s1_mode_reg;
  logic signed [WIDTH-1:0] s1_clamp_reg;
  logic [CNT_W-1:0]        zero_cnt_reg;
  logic                    s2_load;
  logic                    s1_load;
  logic                    in_fire;
  logic                    out_fire;
  logic signed [WIDTH-1:0] clamp_eff;
  logic [LANES-1:0]        lane_zero;
  logic [CNT_W:0]          zero_sum;

  // s1 may refill whenever s2 drains, so in_ready is combinational from out_ready
  assign s2_load   = !s2_valid_reg || out_ready;
  assign s1_load   = !s1_valid_reg || s2_load;
  assign in_ready  = s1_load;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = s2_valid_reg && out_ready;
  assign clamp_eff = clamp_val[WIDTH-1] ? '0 : $signed(clamp_val);

  assign out_valid = s2_valid_reg;
  assign out_last  = s2_last_reg;
  assign zero_cnt  = zero_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
      s1_last_reg  <= 1'b0;
      s2_last_reg  <= 1'b0;
      s1_mode_reg  <= MODE_BYPASS;
      s1_clamp_reg <= '0;
    end else begin
      if (s1_load) begin
        s1_valid_reg <= in_valid;
      end
      if (in_fire) begin
        s1_mode_reg  <= mode;
        s1_clamp_reg <= clamp_eff;
        s1_last_reg  <= in_last;
      end
      if (s2_load) begin
        s2_valid_reg <= s1_valid_reg;
        if (s1_valid_reg) begin
          s2_last_reg <= s1_last_reg;
        end
      end
    end
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic signed [WIDTH-1:0] lane_in;
    logic signed [WIDTH-1:0] s1_data_reg;
    logic signed [WIDTH-1:0] s1_leaky_reg;
    logic                    s1_neg_reg;
    logic                    s1_gt_reg;
    logic signed [WIDTH-1:0] act_next;
    logic signed [WIDTH-1:0] s2_data_reg;

    assign lane_in = $signed(in_data[gi*WIDTH +: WIDTH]);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_data_reg  <= '0;
        s1_leaky_reg <= '0;
        s1_neg_reg   <= 1'b0;
        s1_gt_reg    <= 1'b0;
      end else if (in_fire) begin
        s1_data_reg  <= lane_in;
        s1_leaky_reg <= lane_in >>> LEAK_SHIFT;
        s1_neg_reg   <= lane_in[WIDTH-1];
        s1_gt_reg    <= lane_in > clamp_eff;
      end
    end

    always_comb begin
      act_next = s1_data_reg;
      case (s1_mode_reg)
        MODE_BYPASS: act_next = s1_data_reg;
        MODE_RELU:   act_next = s1_neg_reg ? '0 : s1_data_reg;
        MODE_CLAMP:  act_next = s1_neg_reg ? '0 : (s1_gt_reg ? s1_clamp_reg : s1_data_reg);
        MODE_LEAKY:  act_next = s1_neg_reg ? s1_leaky_reg : s1_data_reg;
        default:     act_next = s1_data_reg;
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s2_data_reg <= '0;
      end else if (s2_load && s1_valid_reg) begin
        s2_data_reg <= act_next;
      end
    end

    assign out_data[gi*WIDTH +: WIDTH] = s2_data_reg;
    assign lane_zero[gi] = (s2_data_reg == '0);
  end

  // A clear coincident with a handshake restarts the count from this beat's zeros
  always_comb begin
    zero_sum = stat_clr ? '0 : {1'b0, zero_cnt_reg};
    for (int i = 0; i < LANES; i++) begin
      zero_sum = zero_sum + {{CNT_W{1'b0}}, lane_zero[i]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_cnt_reg <= '0;
    end else if (out_fire) begin
      zero_cnt_reg <= zero_sum[CNT_W] ? '1 : zero_sum[CNT_W-1:0];
    end else if (stat_clr) begin
      zero_cnt_reg <= '0;
    end
  end

endmodule
